// File: rtl/outport_buffer_if.sv
// Bundle between the 3-input arbiter, the output-port flit queue and the
// output link.
//   grant_i/grant_v_i/flit_i : arbiter grant and the three candidate flits
//   buffer_full_o            : back-pressure to the arbiter
//   data_o/valid_o/ready_i   : FIFO head to the output link
//   count_o/overflow_o       : occupancy and sticky protocol-error flag
// slave  = the queue itself, master = whoever drives the arbiter/link side.
interface outport_buffer_if #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [2:0]          grant_i;
  logic                grant_v_i;
  logic [3*FLIT_W-1:0] flit_i;
  logic                buffer_full_o;
  logic [FLIT_W-1:0]   data_o;
  logic                valid_o;
  logic                ready_i;
  logic [CNT_W-1:0]    count_o;
  logic                overflow_o;

  modport slave (
    input  grant_i, grant_v_i, flit_i, ready_i,
    output buffer_full_o, data_o, valid_o, count_o, overflow_o
  );

  modport master (
    output grant_i, grant_v_i, flit_i, ready_i,
    input  buffer_full_o, data_o, valid_o, count_o, overflow_o
  );
endinterface

// File: rtl/outport_buffer.sv
// Output-port flit queue behind the 3-input arbiter. Muxes the granted
// input's flit into a DEPTH-entry circular FIFO and presents the head to the
// output link with valid/ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : outport_buffer_if.slave (grant/flits in, head/status out)
// All status outputs come straight from registers; nothing on the input side
// reaches an output combinationally.
module outport_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  outport_buffer_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int NUM_IN = 3;

  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              count;
  logic                          overflow;
  logic [DEPTH-1:0][FLIT_W-1:0]  mem;

  logic [NUM_IN-1:0][FLIT_W-1:0] lane_flit;
  logic [FLIT_W-1:0]             sel_flit;
  logic                          onehot, full, empty, push, pop, bad;

  // Per-input masking; the one-hot grant makes the OR of all lanes a mux.
  for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
    assign lane_flit[k] = bus.flit_i[k*FLIT_W +: FLIT_W] & {FLIT_W{bus.grant_i[k]}};
  end

  always_comb begin
    sel_flit = '0;
    for (int k = 0; k < NUM_IN; k++) sel_flit = sel_flit | lane_flit[k];
  end

  assign onehot = (bus.grant_i != 3'b000) && ((bus.grant_i & (bus.grant_i - 3'd1)) == 3'b000);
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);

  // Full is judged on registered state only, so a same-cycle pop never
  // makes room for a grant that arrived while full.
  assign push = bus.grant_v_i & onehot & ~full;
  assign pop  = ~empty & bus.ready_i;
  // Grant while full or a malformed grant is an upstream protocol violation.
  assign bad  = bus.grant_v_i & (~onehot | full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (bad) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; count gates everything read out of it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel_flit;
  end

  assign bus.buffer_full_o = full;
  assign bus.valid_o       = ~empty;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;
  // Forced to zero when empty so reset (count=0) shows data_o=0 immediately.
  assign bus.data_o        = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_outport_buffer.sv
module tb_outport_buffer;
  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  outport_buffer_if #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus ();

  outport_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: a plain queue of flits plus a sticky error bit.
  logic [FLIT_W-1:0] q[$];
  bit                ovf_m;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 64'(bus.count_o), 64'(q.size()));
    check({tag, ".valid"}, 64'(bus.valid_o), 64'(q.size() != 0));
    check({tag, ".full"},  64'(bus.buffer_full_o), 64'(q.size() == DEPTH));
    check({tag, ".data"},  64'(bus.data_o), (q.size() != 0) ? 64'(q[0]) : 64'd0);
    check({tag, ".ovf"},   64'(bus.overflow_o), 64'(ovf_m));
  endtask

  // One clock: drive at negedge, model the cycle's rules, compare #1 after posedge.
  task automatic step(input logic [2:0] g, input logic gv,
                      input logic [3*FLIT_W-1:0] f, input logic rdy, input string tag);
    bit is_oh, do_push, do_pop;
    logic [FLIT_W-1:0] sel;
    @(negedge clk);
    bus.grant_i = g; bus.grant_v_i = gv; bus.flit_i = f; bus.ready_i = rdy;
    is_oh   = $countones(g) == 1;
    do_push = gv && is_oh && (q.size() < DEPTH);
    do_pop  = rdy && (q.size() > 0);
    sel = '0;
    for (int k = 0; k < 3; k++) if (g[k]) sel = f[k*FLIT_W +: FLIT_W];
    @(posedge clk);
    #1;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(sel);
    if (gv && !do_push) ovf_m = 1'b1;
    check_all(tag);
  endtask

  function automatic logic [3*FLIT_W-1:0] on_input(input int k, input logic [FLIT_W-1:0] v);
    logic [3*FLIT_W-1:0] f;
    f = {$urandom(), $urandom(), $urandom()};
    f[k*FLIT_W +: FLIT_W] = v;
    return f;
  endfunction

  function automatic logic [3*FLIT_W-1:0] rnd_flits();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Mid-cycle asynchronous reset, checked before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    bus.grant_v_i = 1'b0; bus.ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    q.delete(); ovf_m = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [2:0] g;
    bus.grant_i = '0; bus.grant_v_i = 1'b0; bus.flit_i = '0; bus.ready_i = 1'b0;
    q.delete(); ovf_m = 1'b0;
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: single push on input 1, one-cycle latency
    step(3'b010, 1'b1, on_input(1, 32'hA5A5_0001), 1'b0, "t1_push");
    step(3'b000, 1'b0, rnd_flits(), 1'b1, "t1_pop");

    // 2: fill in order from inputs 0,2,1,0 then drain
    step(3'b001, 1'b1, on_input(0, 32'h10), 1'b0, "t2_w0");
    step(3'b100, 1'b1, on_input(2, 32'h11), 1'b0, "t2_w1");
    step(3'b010, 1'b1, on_input(1, 32'h12), 1'b0, "t2_w2");
    step(3'b001, 1'b1, on_input(0, 32'h13), 1'b0, "t2_w3");
    check("t2_full", 64'(bus.buffer_full_o), 64'd1);
    for (int i = 0; i < 4; i++) step(3'b000, 1'b0, rnd_flits(), 1'b1, "t2_drain");
    check("t2_empty", 64'(bus.valid_o), 64'd0);

    // 3: grant while full with a same-cycle pop: no write, overflow sticks
    for (int i = 0; i < 4; i++) step(3'b001, 1'b1, on_input(0, 32'h20 + i), 1'b0, "t3_fill");
    step(3'b100, 1'b1, on_input(2, 32'hDEAD), 1'b1, "t3_ovf");
    check("t3_count3", 64'(bus.count_o), 64'd3);
    check("t3_ovf1", 64'(bus.overflow_o), 64'd1);
    step(3'b000, 1'b0, rnd_flits(), 1'b0, "t3_sticky");

    // 4: steady push+pop at count=2 across pointer wraps
    async_reset("t4_rst");
    step(3'b001, 1'b1, on_input(0, 32'h30), 1'b0, "t4_pre0");
    step(3'b010, 1'b1, on_input(1, 32'h31), 1'b0, "t4_pre1");
    for (int i = 0; i < 10; i++) begin
      g = 3'b001 << (i % 3);
      step(g, 1'b1, on_input(i % 3, 32'h40 + i), 1'b1, "t4_pp");
    end
    check("t4_count2", 64'(bus.count_o), 64'd2);

    // 5: malformed grant and ignored grant
    async_reset("t5_rst");
    step(3'b001, 1'b0, rnd_flits(), 1'b0, "t5_gv0");
    step(3'b011, 1'b1, rnd_flits(), 1'b0, "t5_bad");
    check("t5_ovf1", 64'(bus.overflow_o), 64'd1);
    step(3'b000, 1'b1, rnd_flits(), 1'b0, "t5_zero");

    // 6: async reset with three queued flits, then a clean push
    async_reset("t6_pre");
    for (int i = 0; i < 3; i++) step(3'b100, 1'b1, on_input(2, 32'h50 + i), 1'b0, "t6_fill");
    async_reset("t6_rst");
    step(3'b010, 1'b1, on_input(1, 32'hBEEF_0001), 1'b0, "t6_push");

    // Random traffic against the queue model
    async_reset("rnd_rst");
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 16) g = 3'b001 << $urandom_range(0, 2);
      else        g = 3'($urandom_range(0, 7));
      // Occasionally drop overflow state so later violations remain observable.
      if (i % 100 == 99) async_reset("rnd_rst2");
      step(g, $urandom_range(0, 9) < 6, rnd_flits(), $urandom_range(0, 9) < 5, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
